// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in, serial-out stage. Accepts a WIDTH-bit word over a
//               valid/ready handshake and emits it LSB first, one bit per clk,
//               qualified by ser_valid. Words may stream back-to-back.
//               Optional even-parity bit after the data bits is enabled by
//               defining the macro PISO_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer #(
  parameter int WIDTH      = 4,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_last,
  output logic             busy
);

  localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             last_data;
  logic             accept;

`ifdef PISO_PARITY_EN
  logic             parity, parity_nxt;
`endif

  // Bit 0 of shreg is always the bit currently on the line.
  assign last_data = (state == SHIFT) && (cnt == LAST_CNT);
`ifdef PISO_PARITY_EN
  assign frame_last = (state == PAR);
`else
  assign frame_last = last_data;
`endif
  assign in_ready  = (state == IDLE) || frame_last;
  assign accept    = in_valid && in_ready;
  assign ser_valid = (state != IDLE);
  assign busy      = (state != IDLE);

  // Serial line mux: data bit, parity bit, or the idle level.
  always_comb begin
    ser_out = IDLE_LEVEL;
    if (state == SHIFT) begin
      ser_out = shreg[0];
    end
`ifdef PISO_PARITY_EN
    else if (state == PAR) begin
      ser_out = parity;
    end
`endif
  end

  // Next-state logic: a new word is loaded on any accepting edge, otherwise
  // shift while bits remain and fall back to IDLE at frame end.
  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    cnt_nxt    = cnt;
`ifdef PISO_PARITY_EN
    parity_nxt = parity;
`endif
    if (accept) begin
      state_nxt  = SHIFT;
      shreg_nxt  = in_data;
      cnt_nxt    = '0;
`ifdef PISO_PARITY_EN
      parity_nxt = ^in_data;
`endif
    end else begin
      case (state)
        IDLE: begin
          state_nxt = IDLE;
        end
        SHIFT: begin
          if (cnt == LAST_CNT) begin
`ifdef PISO_PARITY_EN
            state_nxt = PAR;
`else
            state_nxt = IDLE;
`endif
            cnt_nxt   = '0;
            shreg_nxt = '0;
          end else begin
            cnt_nxt   = cnt + CNT_W'(1);
            shreg_nxt = shreg >> 1;
          end
        end
`ifdef PISO_PARITY_EN
        PAR: begin
          state_nxt = IDLE;
        end
`endif
        default: begin
          state_nxt = IDLE;
          shreg_nxt = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State register; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
`ifdef PISO_PARITY_EN
      parity <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      cnt    <= cnt_nxt;
`ifdef PISO_PARITY_EN
      parity <= parity_nxt;
`endif
    end
  end

endmodule
`default_nettype wire

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out stage that feeds the 4-bit SIPO shift register.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it LSB first, one bit per clk.
- After WIDTH data bits, the downstream SIPO holds the original word with out[WIDTH-1:0] equal to in_data.
- Qualified by ser_valid so downstream logic knows when a frame is complete.

Parameters:
- WIDTH, 4, data word width in bits; legal range 2..16.
- IDLE_LEVEL, 0, value driven on ser_out when no bit is being sent.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  in_data is presented.
- in_ready  output  1  block accepts a word on this edge when in_valid=1.
- ser_out  output  1  serial data bit, LSB first.
- ser_valid  output  1  ser_out carries a frame bit this cycle.
- frame_last  output  1  ser_out is the final bit of the frame.
- busy  output  1  frame in progress; equals (state != IDLE).

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, shift register=0, bit counter=0.
  - ser_out=IDLE_LEVEL, ser_valid=0, frame_last=0, busy=0.
  - in_ready=1 in the cycle after reset.
  - rst has priority over all other inputs and aborts any frame mid-shift; no further bits of the aborted word are emitted.
- States:
  - IDLE: no frame in progress.
  - SHIFT: data bits being sent.
  - PAR: parity bit; exists only with PARITY_EN.
- Accept: a transfer occurs at an edge where in_valid=1 and in_ready=1. in_data is captured in that edge; no combinational path from in_data to ser_out.
- Latency: bit 0 of the captured word is on ser_out in the cycle after the accept edge. Bit k is on ser_out in cycle k+1 after accept. ser_valid=1 for exactly WIDTH consecutive cycles per frame.
- in_ready:
  - 1 in IDLE.
  - 1 during the final cycle of a frame, i.e. while frame_last=1.
  - 0 otherwise.
  - Words can therefore stream back-to-back with no idle cycle: ser_valid stays 1 continuously and the next frame's bit 0 follows the previous frame's last bit.
- Transitions:
  - IDLE -> SHIFT on accept.
  - SHIFT with counter=WIDTH-1: -> SHIFT (counter=0, new word) if accepting; otherwise -> IDLE.
  - SHIFT otherwise: counter+1, shift right by one.
- Counter: width $clog2(WIDTH), wraps to 0 at frame end, never exceeds WIDTH-1.
- frame_last=1 exactly when ser_valid=1 and the current bit is the last bit of the frame.
- In IDLE: ser_out=IDLE_LEVEL and ser_valid=0.
- in_valid held high while in_ready=0: no effect, no word lost or duplicated; the word is taken at the next in_ready edge.
- in_data changing while in_ready=0: ignored.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra cycle in state PAR drives the even parity bit (XOR of all data bits).
  - ser_valid=1 in that cycle; frame is WIDTH+1 bits.
  - frame_last and in_ready move to the PAR cycle and are 0 on the last data bit.
  - PAR -> SHIFT on accept, else -> IDLE.
- Undefined: PAR state, parity logic and extra cycle do not exist; frame is WIDTH bits.

Test Plan:
- Reset then one word: rst 2 cycles, in_data=4'b1011 with in_valid for 1 accept edge -> ser_out 1,1,0,1 on cycles 1..4 with ser_valid=1, frame_last only on cycle 4. Attached SIPO out=4'b1011 after cycle 4. ser_valid=0 on cycle 5.
- Back-to-back: in_valid held high with words 4'hA then 4'h5 -> 8 contiguous ser_valid cycles with bits 0,1,0,1,1,0,1,0; in_ready pulses on cycles 4 and 8; no gap.
- Stall: in_valid=1 with 4'hF at accept, then in_data changed to 4'h0 while in_ready=0 -> frame is 1,1,1,1. The 4'h0 word is accepted only at the frame_last edge and emitted 0,0,0,0.
- Reset mid-frame: accept 4'hC, assert rst on cycle 2 -> ser_valid=0, ser_out=IDLE_LEVEL, busy=0 the next cycle. in_ready=1 and the following accept of 4'h3 emits 1,1,0,0 cleanly.
- Idle hold: no in_valid for 20 cycles after reset -> ser_out=IDLE_LEVEL, ser_valid=0, busy=0 throughout.
- PISO_PARITY_EN build: in_data=4'b0111 -> bits 1,1,1,0 then parity 1 on cycle 5 with frame_last=1. in_data=4'b0101 -> parity bit 0.
